dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter sharing the single-ported `data_mem` between the core load/store unit (port 0) and the DMA/debug loader (port 1).
- Issues at most one access per cycle.
- Arbitration is round-robin, or fixed priority with an anti-starvation timer.
- Registers read data and an error flag back to the granted requester.
- Sits between the core memory stage, the DMA engine and `data_mem`.

Parameters:
- `FIXED_PRIO`, 0, 0 = round-robin; 1 = port 0 always wins unless the starvation timer fires.
- `MAX_WAIT`, 8, cycles port 1 may wait under `FIXED_PRIO` before it is forced to win; legal 1..255.
- `MEM_BYTES`, 8192, byte size of the data memory; addresses at or above this are out of range.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `m0_req_i` in 1: port 0 request.
- `m0_we_i` in 1: port 0 write enable; 0 = read.
- `m0_addr_i` in 32: port 0 byte address.
- `m0_wdata_i` in 32: port 0 write data.
- `m0_ack_o` out 1: port 0 request accepted this cycle.
- `m0_rvalid_o` out 1: port 0 response valid.
- `m0_rdata_o` out 32: port 0 read data.
- `m0_err_o` out 1: port 0 response error.
- `m1_req_i`, `m1_we_i`, `m1_addr_i`, `m1_wdata_i`, `m1_ack_o`, `m1_rvalid_o`, `m1_rdata_o`, `m1_err_o`: same as port 0, for port 1.
- `mem_req_o` out 1: request to `data_mem`.
- `mem_we_o` out 1: write enable to `data_mem`.
- `mem_waddr_o` out 32: write byte address.
- `mem_wdata_o` out 32: write data.
- `mem_raddr_o` out 32: read byte address.
- `mem_rdata_i` in 32: combinational read data from `data_mem`.

Behaviour:
- **Reset** (`rst`=1 at `posedge clk`):
  - All `*_rvalid_o`, `*_err_o` = 0; `*_rdata_o` = 0.
  - Round-robin pointer = port 0 (port 0 wins the next tie).
  - Wait counter = 0.
  - While `rst` is high: `*_ack_o` = 0 and `mem_req_o` = 0.
  - A request in flight during reset is dropped; no response is produced.
- **Handshake:**
  - A requester holds `req`, `we`, `addr`, `wdata` stable until it sees `ack`.
  - `ack` is combinational and is asserted in the cycle the access is issued.
  - At most one of `m0_ack_o`/`m1_ack_o` is high per cycle.
  - No request → both `ack` = 0 and `mem_req_o` = 0.
- **Arbitration, both requesting:**
  - `FIXED_PRIO`=0: grant the port not granted last; pointer updates only on a grant.
  - `FIXED_PRIO`=1: grant port 0, unless wait counter == `MAX_WAIT`, then grant port 1.
  - Single requester: always granted.
- **Wait counter** (`FIXED_PRIO`=1 only):
  - Increments each cycle `m1_req_i`=1 and port 1 is not granted; saturates at `MAX_WAIT`.
  - Clears when port 1 is granted or `m1_req_i`=0.
- **Address check:**
  - Error when `addr[1:0]` != 0 or `addr` >= `MEM_BYTES`.
  - An erroring request is still acked, but `mem_req_o` = 0 (no write).
  - Its response has `err` = 1 and `rdata` = 0.
- **Memory drive for the granted, legal access:**
  - `mem_req_o` = 1, `mem_we_o` = granted `we`.
  - `mem_waddr_o` = `mem_raddr_o` = granted `addr`; `mem_wdata_o` = granted `wdata`.
  - Ungranted cycles: `mem_we_o` = 0 and addresses/data = 0.
  - The write lands at the next `posedge`.
- **Response:**
  - Registered; appears exactly 1 cycle after `ack` on the acked port only.
  - `rvalid` is high for one cycle for both reads and writes.
  - Reads: `rdata` = `mem_rdata_i` sampled in the ack cycle.
  - Writes: `rdata` = 0.
  - In all other cycles `rvalid` = 0; `rdata` and `err` are held at 0.
- **Throughput and ordering:**
  - Back-to-back accesses are allowed: one ack per cycle, 100% throughput.
  - A read following a write to the same address in the next cycle returns the new data, because memory updates at the edge.

Test Plan:
1. Reset, then port 0 writes 0xDEADBEEF to 0x10 and then reads 0x10.
   → `m0_ack_o` high in each issue cycle; the read response 1 cycle later has `rvalid`=1, `rdata`=0xDEADBEEF, `err`=0.
2. `FIXED_PRIO`=0, both ports request continuously with reads.
   → Grants alternate 0,1,0,1 starting with port 0 after reset; each port gets one `rvalid` per 2 cycles.
3. `FIXED_PRIO`=1, `MAX_WAIT`=3, both request continuously.
   → Port 0 is acked 3 cycles, then port 1 is acked in cycle 4; the counter clears and the pattern repeats.
4. Port 1 writes to 0x2 (misaligned) and to 0x2000 (out of range).
   → Both are acked; `mem_req_o` stays 0; responses have `err`=1, `rdata`=0; a later read of 0x0 is unchanged.
5. Port 0 write is acked, then `rst` is asserted in the following cycle.
   → No `rvalid`; all outputs 0 during reset; after release the pointer is port 0 and the counter is 0.
6. Same-cycle requests: port 0 writes 0x55 to 0x20 while port 1 reads 0x20, with `FIXED_PRIO`=0 from reset.
   → Port 0 writes first; port 1 is acked the next cycle and returns 0x55.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data_mem between the core LSU (port 0) and the DMA/debug loader (port 1).
// Latency: ack is combinational in the issue cycle; rvalid/rdata/err are registered, one cycle after ack.
// Backpressure: a requester holds req/we/addr/wdata until it sees ack; the losing port simply gets no ack.
// Ports: clk, rst (sync, active-high); m0_*/m1_* request side (req, we, addr, wdata) and response side
//        (ack, rvalid, rdata, err); mem_* drive data_mem, mem_rdata_i is its combinational read data.

module dmem_arbiter #(
  parameter int FIXED_PRIO = 0,     // 0 = round-robin, 1 = port 0 wins unless port 1 has starved
  parameter int MAX_WAIT   = 8,     // cycles port 1 may lose under fixed priority (1..255)
  parameter int MEM_BYTES  = 8192   // byte size of data_mem
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] mem_raddr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [32:0] MEM_LIMIT  = 33'(MEM_BYTES);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t acc0;
  acc_t acc1;
  acc_t sel;

  logic       tie_p1;     // port 1 wins the next round-robin tie
  logic [7:0] wait_cnt;   // cycles port 1 has been requesting without a grant
  logic       gnt0;
  logic       gnt1;
  logic       gnt_any;
  logic       sel_err;
  logic       issue;
  logic       rd_ok;

  logic        rvalid0_q;
  logic        err0_q;
  logic [31:0] rdata0_q;
  logic        rvalid1_q;
  logic        err1_q;
  logic [31:0] rdata1_q;

  assign acc0 = '{we: m0_we_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign acc1 = '{we: m1_we_i, addr: m1_addr_i, wdata: m1_wdata_i};

  // Misaligned or beyond the end of data_mem.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= MEM_LIMIT);
  endfunction

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req_i && m1_req_i) begin
        if (FIXED_PRIO != 0) gnt1 = (wait_cnt == MAX_WAIT_C);
        else                 gnt1 = tie_p1;
        gnt0 = !gnt1;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign sel     = gnt1 ? acc1 : acc0;
  assign sel_err = addr_bad(sel.addr);
  // An erroring access is acked but never reaches data_mem.
  assign issue   = gnt_any & ~sel_err;
  assign rd_ok   = issue & ~sel.we;

  assign m0_ack_o    = gnt0;
  assign m1_ack_o    = gnt1;

  assign mem_req_o   = issue;
  assign mem_we_o    = issue & sel.we;
  assign mem_waddr_o = issue ? sel.addr  : 32'd0;
  assign mem_raddr_o = issue ? sel.addr  : 32'd0;
  assign mem_wdata_o = issue ? sel.wdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tie_p1    <= 1'b0;
      wait_cnt  <= '0;
      rvalid0_q <= 1'b0;
      err0_q    <= 1'b0;
      rdata0_q  <= '0;
      rvalid1_q <= 1'b0;
      err1_q    <= 1'b0;
      rdata1_q  <= '0;
    end else begin
      // After serving port 0, port 1 takes the next tie, and vice versa.
      if (gnt_any) tie_p1 <= gnt0;

      if ((FIXED_PRIO != 0) && m1_req_i && !gnt1) begin
        if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end

      rvalid0_q <= gnt0;
      err0_q    <= gnt0 & sel_err;
      rdata0_q  <= (gnt0 & rd_ok) ? mem_rdata_i : 32'd0;
      rvalid1_q <= gnt1;
      err1_q    <= gnt1 & sel_err;
      rdata1_q  <= (gnt1 & rd_ok) ? mem_rdata_i : 32'd0;
    end
  end

  // Responses are masked while reset is high so an access acked just before
  // reset never produces a response.
  assign m0_rvalid_o = rvalid0_q & ~rst;
  assign m0_err_o    = err0_q & ~rst;
  assign m0_rdata_o  = rst ? 32'd0 : rdata0_q;
  assign m1_rvalid_o = rvalid1_q & ~rst;
  assign m1_err_o    = err1_q & ~rst;
  assign m1_rdata_o  = rst ? 32'd0 : rdata1_q;

endmodule
